// File: rtl/vga_rle_pkg.sv
// Shared definitions for the RLE pixel-instruction encoder.
// Instruction word layout: {rgb[18:10], run_len_minus1[9:0]}.
package vga_rle_pkg;

    localparam int INSTR_W = 19;
    localparam int RGB_W   = 9;
    localparam int RUN_W   = 10;

    localparam logic [RUN_W-1:0] RUN_MAX = 10'd1023;

    localparam int RGB_MSB = INSTR_W - 1;
    localparam int RGB_LSB = RUN_W;
    localparam int RUN_MSB = RUN_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } rle_state_e;

    function automatic logic [INSTR_W-1:0] pack_instr(input logic [RGB_W-1:0] rgb,
                                                      input logic [RUN_W-1:0] run);
        return {rgb, run};
    endfunction

    function automatic logic [RGB_W-1:0] instr_rgb(input logic [INSTR_W-1:0] instr);
        return instr[RGB_MSB:RGB_LSB];
    endfunction

    function automatic logic [RUN_W-1:0] instr_run(input logic [INSTR_W-1:0] instr);
        return instr[RUN_MSB:0];
    endfunction

endpackage

// File: rtl/rle_out_slot.sv
// Single-entry output register with valid/ready handshake.
// The slot is free when empty or when its current word is being taken.
module rle_out_slot
    import vga_rle_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         free
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    assign free      = ~valid_q | out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    // Next slot contents: a load wins, otherwise a taken word empties the slot.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rle_instruction_encoder.sv
// Run-length encoder: merges runs of identical 9-bit pixels into 19-bit
// {rgb, run-1} instructions. Optional macro RLE_LINE_SPLIT_EN makes pix_last
// close the open run so runs never span lines.
module rle_instruction_encoder
    import vga_rle_pkg::*;
#(
    parameter int RUN_W = 10,
    parameter int RGB_W = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RGB_W-1:0]       pix_in,
    input  logic                   pix_valid,
    input  logic                   pix_last,
    output logic                   pix_ready,
    input  logic                   flush,
    output logic [RGB_W+RUN_W-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    rle_state_e             state_q, state_d;
    logic [RGB_W-1:0]       cur_q, cur_d;
    logic [RUN_W-1:0]       cnt_q, cnt_d;
    logic                   hold_q, hold_d;
    logic [RUN_W-1:0]       cnt_inc;
    logic                   slot_free;
    logic                   load;
    logic [RGB_W+RUN_W-1:0] load_data;
    logic                   accept;
    logic                   line_close;
    logic                   close_now;

`ifdef RLE_LINE_SPLIT_EN
    assign line_close = pix_last;
`else
    logic line_unused;
    assign line_close  = 1'b0;
    assign line_unused = pix_last;
`endif

    assign pix_ready = slot_free & (state_q != PEND) & rst_n;
    assign accept    = pix_valid & pix_ready;
    // A flush that found the slot busy stays pending in hold_q until it lands.
    assign close_now = flush | hold_q | line_close;
    assign cnt_inc   = cnt_q + 1'b1;

    // Run tracking and instruction generation.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        hold_d    = 1'b0;
        load      = 1'b0;
        load_data = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_d = pix_in;
                    cnt_d = '0;
                    if (close_now) begin
                        load      = 1'b1;
                        load_data = pack_instr(pix_in, '0);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (pix_in == cur_q) begin
                        cnt_d = cnt_inc;
                        if ((cnt_inc == RUN_MAX) || close_now) begin
                            load      = 1'b1;
                            load_data = pack_instr(cur_q, cnt_inc);
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end
                    end else begin
                        load      = 1'b1;
                        load_data = pack_instr(cur_q, cnt_q);
                        cur_d     = pix_in;
                        cnt_d     = '0;
                        if (close_now) begin
                            state_d = PEND;
                        end
                    end
                end else if (flush | hold_q) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_data = pack_instr(cur_q, cnt_q);
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
            end
            PEND: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = pack_instr(cur_q, '0);
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Encoder state registers; an open run is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    rle_out_slot #(
        .W(RGB_W + RUN_W)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .out_ready (instr_ready),
        .out_data  (instr_out),
        .out_valid (instr_valid),
        .free      (slot_free)
    );

endmodule

// File: doc/rle_instruction_encoder.md
# rle_instruction_encoder

Run-length encoder producing the 19-bit pixel instruction stream that the on-chip instruction decoder consumes, i.e. the write side of the flash video format. It takes a raster stream of 9-bit RGB pixels, merges runs of identical colour, and emits one instruction per run through a valid/ready handshake. It sits in the FPGA capture/test harness and the flash-image generation path, and its output is written to QSPI flash for the video player to read back.

## Interface
Parameters:
- RUN_W, 10, run-length field width; max run 2^RUN_W = 1024 pixels
- RGB_W, 9, colour width ({R[2:0],G[2:0],B[2:0]})

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- pix_in  in  9  pixel colour
- pix_valid  in  1  pix_in is valid
- pix_last  in  1  last pixel of a line; qualified by pix_valid
- pix_ready  out  1  encoder accepts the pixel this cycle
- flush  in  1  close the open run (end of frame/stream)
- instr_out  out  19  {rgb[18:10], run_len_minus1[9:0]}
- instr_valid  out  1  instr_out holds an instruction
- instr_ready  in  1  downstream takes instr_out this cycle

## Operation
- Instruction format: bits [18:10] are the colour. Bits [9:0] are the run count minus 1 (1..1024 pixels). A run never holds more than 1024 pixels.
- Pixel accept is pix_valid & pix_ready. Instruction transfer is instr_valid & instr_ready.
- pix_ready = (~instr_valid | instr_ready) & (state != PEND) & rst_n. An accepted pixel always has a free output slot.
- States:
  - IDLE: no open run.
  - RUN: open run with colour cur and counter cnt (count-1).
  - PEND: a 1-pixel run is waiting for the output slot.
- IDLE, on accept: cur=pix_in, cnt=0, go to RUN. If a close condition holds, emit {pix_in,0} and stay in IDLE.
- RUN, accept, pix_in==cur: cnt+1.
  - If the new cnt is 1023 or a close condition holds, emit {cur,new cnt} and go to IDLE.
- RUN, accept, pix_in!=cur: emit {cur,cnt}, then cur=pix_in, cnt=0.
  - If a close condition holds, go to PEND (the second instruction is still owed). Otherwise stay in RUN.
- PEND: when the slot is free, load {cur,0} and go to IDLE.
- Close condition: pix_last (line split enabled), or flush asserted in the same cycle.
- flush with no accept:
  - In RUN, emit {cur,cnt} once the slot is free, then go to IDLE. If the slot is busy, the close is held and retried until the slot frees.
  - In IDLE or PEND, flush is ignored; PEND drains on its own.
- instr_out and instr_valid stay stable while instr_valid & ~instr_ready.

## Timing
- Latency: the instruction is registered and valid the cycle after the closing pixel or flush is accepted.
- Full throughput: 1 pixel/cycle while instr_ready is high. The exception is one extra bubble cycle for PEND, which occurs when a colour change and a close happen in the same cycle.
- Back-pressure: when instr_ready is low and instr_valid is high, pix_ready drops combinationally in the same cycle.
- Reset (async assert, sync-released internally by the flops' normal use):
  - state=IDLE, cnt=0, cur=0
  - instr_out=0, instr_valid=0
  - pix_ready=0 while rst_n is low
  - An open run is discarded on reset mid-stream.
- Counter wrap: cnt never exceeds 1023. At 1023 the run closes, and the next equal pixel opens a fresh run with cnt=0.

## Configuration
- RLE_LINE_SPLIT_EN defined: pix_last is a close condition, so runs never span lines. This matches the decoder's per-line pixel requests.
- RLE_LINE_SPLIT_EN undefined: pix_last is ignored. Runs span line boundaries and close only on colour change, the 1024-pixel limit, or flush.

## Structure
- Shared package vga_rle_pkg holds:
  - INSTR_W=19, RGB_W=9, RUN_W=10
  - RUN_MAX=10'd1023
  - state enum {IDLE, RUN, PEND}
  - field-slice functions/localparams for colour [18:10] and run [9:0]
- One sub-module, rle_out_slot: a single-entry output register with valid/ready, load, and a free flag. The encoder FSM and counter stay in the top module.

## Test plan
- Line split enabled, 640 pixels of 9'h1C0, last pixel with pix_last, instr_ready=1 → one instruction 19'h{1C0,10'd639} one cycle after the last accept.
- Colours A,A,A,B, with B carrying pix_last (split enabled) → {A,2}, then {B,0} after one PEND bubble. pix_ready is low for exactly one cycle.
- 1030 pixels of 9'h0FF, then flush → {0FF,1023}, then {0FF,5}.
- instr_ready held low for 10 cycles while an instruction is pending → pix_ready stays 0, and instr_out/instr_valid stay constant until ready rises.
- RLE_LINE_SPLIT_EN undefined: two lines of 9'h007 (4 pixels each, pix_last on the 4th), then flush → a single {007,7}.
- rst_n pulled low mid-run after 5 pixels → instr_valid=0 and pix_ready=0 immediately. After release, fresh pixels produce runs starting at count 0 with no stale instruction.
